// File: rtl/id_stage.sv
// Instruction decode stage: field decode, register-file read, valid/ready output register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data to the operands.
module id_stage #(
    parameter int unsigned INST_LEN = 17,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned REG_N    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [INST_LEN-1:0]        in_inst,
    output logic                       in_ready,
    input  logic                       wb_en,
    input  logic [$clog2(REG_N)-1:0]   wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_op,
    output logic [DATA_W-1:0]          out_a,
    output logic [DATA_W-1:0]          out_b,
    output logic [$clog2(REG_N)-1:0]   out_rd,
    output logic                       out_we,
    output logic                       out_illegal,
    output logic [7:0]                 dec_count
);

    localparam int unsigned AW = $clog2(REG_N);

    logic [DATA_W-1:0] regs_q [REG_N];
    logic [DATA_W-1:0] regs_d [REG_N];

    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_op_q, out_op_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic [AW-1:0]     out_rd_q, out_rd_d;
    logic              out_we_q, out_we_d;
    logic              out_illegal_q, out_illegal_d;
    logic [7:0]        dec_count_q, dec_count_d;

    logic              accept;
    logic [3:0]        f_op;
    logic [AW-1:0]     f_rd, f_rs1, f_rs2;
    logic [3:0]        f_imm;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] dec_a, dec_b;
    logic              dec_we, dec_illegal;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign f_op    = in_inst[16:13];
    assign f_rd    = in_inst[12:10];
    assign f_rs1   = in_inst[9:7];
    assign f_rs2   = in_inst[6:4];
    assign f_imm   = in_inst[3:0];
    assign imm_ext = {{(DATA_W-4){f_imm[3]}}, f_imm};

    // Register reads; r0 is hardwired to zero regardless of stored contents.
    always_comb begin
        rd_a = (f_rs1 == '0) ? '0 : regs_q[f_rs1];
        rd_b = (f_rs2 == '0) ? '0 : regs_q[f_rs2];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_addr == f_rs1 && f_rs1 != '0) rd_a = wb_data;
        if (wb_en && wb_addr == f_rs2 && f_rs2 != '0) rd_b = wb_data;
`endif
    end

    always_comb begin
        dec_a       = rd_a;
        dec_b       = rd_b;
        dec_we      = 1'b0;
        dec_illegal = 1'b0;
        case (f_op)
            4'd0: ;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: dec_we = (f_rd != '0);
            4'd6: begin
                dec_b  = imm_ext;
                dec_we = (f_rd != '0);
            end
            4'd7: begin
                dec_a  = '0;
                dec_b  = imm_ext;
                dec_we = (f_rd != '0);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_addr != '0) regs_d[wb_addr] = wb_data;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_rd_d      = out_rd_q;
        out_we_d      = out_we_q;
        out_illegal_d = out_illegal_q;
        dec_count_d   = dec_count_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_op_d      = f_op;
            out_a_d       = dec_a;
            out_b_d       = dec_b;
            out_rd_d      = f_rd;
            out_we_d      = dec_we;
            out_illegal_d = dec_illegal;
            dec_count_d   = dec_count_q + 8'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_rd_q      <= '0;
            out_we_q      <= 1'b0;
            out_illegal_q <= 1'b0;
            dec_count_q   <= '0;
            for (int i = 0; i < int'(REG_N); i++) regs_q[i] <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_rd_q      <= out_rd_d;
            out_we_q      <= out_we_d;
            out_illegal_q <= out_illegal_d;
            dec_count_q   <= dec_count_d;
            regs_q        <= regs_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_rd      = out_rd_q;
    assign out_we      = out_we_q;
    assign out_illegal = out_illegal_q;
    assign dec_count   = dec_count_q;

endmodule
